// File: rtl/busca_instrucao_if.sv
// ---------------------------------------------------------------------------
// busca_instrucao_if
//   Bundles the program-load, control and decoded-field signals of the
//   instruction fetch unit so they can be passed around as a single port.
//
//   Parameters:
//     ADDR_W        word-address width of the instruction memory
//
//   Signals (direction seen from the fetch unit, modport slave):
//     prog_we       in   program-load write enable (honoured only in IDLE)
//     prog_addr     in   word address for program load
//     prog_data     in   instruction word to store
//     start         in   IDLE -> RUN request
//     stall         in   hold fetch state for this cycle
//     branch_taken  in   instruction on the outputs is a taken branch
//     tipo          out  instr[6:4]
//     funct3        out  instr[14:12]
//     funct7        out  instr[31:25]
//     rs1/rs2/rd    out  register indices
//     imm           out  sign-extended immediate selected by tipo
//     pc_out        out  byte address of the issued instruction
//     valid         out  outputs carry a real instruction
//     halted        out  unit is in HALT
//     illegal       out  HALT was caused by an illegal opcode
//
//   The master modport is the driver side (control unit or testbench).
// ---------------------------------------------------------------------------
interface busca_instrucao_if #(
  parameter int ADDR_W = 6
);
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [31:0]       prog_data;
  logic              start;
  logic              stall;
  logic              branch_taken;

  logic [2:0]        tipo;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [4:0]        rd;
  logic [31:0]       imm;
  logic [31:0]       pc_out;
  logic              valid;
  logic              halted;
  logic              illegal;

  modport master (
    output prog_we, prog_addr, prog_data, start, stall, branch_taken,
    input  tipo, funct3, funct7, rs1, rs2, rd, imm, pc_out, valid, halted, illegal
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, start, stall, branch_taken,
    output tipo, funct3, funct7, rs1, rs2, rd, imm, pc_out, valid, halted, illegal
  );
endinterface

// File: rtl/busca_instrucao.sv
// ---------------------------------------------------------------------------
// busca_instrucao
//   Instruction fetch and field-extraction unit for the single-cycle RISC-V
//   datapath. Holds a loadable instruction memory and a program counter and
//   issues one instruction per cycle as decoded fields. Taken branches
//   redirect the PC and squash the slot that was fetched behind them.
//
//   Parameters:
//     MEM_WORDS   instruction memory depth in 32-bit words
//     ADDR_W      word-address width (2**ADDR_W >= MEM_WORDS)
//
//   Ports:
//     clk         single clock, rising edge
//     reset       synchronous, active-high reset
//     bus         busca_instrucao_if.slave (program load, control, fields)
//
//   Optional feature macro: BUSCA_ILLEGAL_HALT_EN
//     Defined   -> a nonzero fetched word whose opcode is not lw/sw/R-type/beq
//                  halts the unit and raises illegal.
//     Undefined -> no opcode checking; illegal is tied to 0.
// ---------------------------------------------------------------------------
module busca_instrucao #(
  parameter int MEM_WORDS = 64,
  parameter int ADDR_W    = 6
) (
  input  logic             clk,
  input  logic             reset,
  busca_instrucao_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_stateNext;

  logic [31:0] r_mem [MEM_WORDS];

  // PCs are kept as word addresses; the byte address always has [1:0] = 0.
  logic [29:0] r_pcWord;
  logic [29:0] r_pcOutWord;

  logic [2:0]  r_tipo;
  logic [2:0]  r_funct3;
  logic [6:0]  r_funct7;
  logic [4:0]  r_rs1;
  logic [4:0]  r_rs2;
  logic [4:0]  r_rd;
  logic [31:0] r_imm;
  logic        r_valid;

  logic [31:0] w_word;
  logic        w_outOfRange;
  logic        w_isZero;
  logic        w_isIllegal;
  logic        w_doFetch;
  logic        w_doBranch;
  logic        w_doHalt;
  logic [29:0] w_branchTarget;

  // Immediate format is chosen by opcode[6:4]: lw (I), sw (S), beq (B);
  // everything else, R-type included, carries no immediate.
  function automatic logic [31:0] selectImm(input logic [31:0] w);
    logic [31:0] result;
    case (w[6:4])
      3'b000:  result = {{20{w[31]}}, w[31:20]};
      3'b010:  result = {{20{w[31]}}, w[31:25], w[11:7]};
      3'b110:  result = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      default: result = 32'h0000_0000;
    endcase
    return result;
  endfunction

  assign w_word       = r_mem[r_pcWord[ADDR_W-1:0]];
  assign w_outOfRange = (r_pcWord >= 30'(MEM_WORDS));
  assign w_isZero     = (w_word == 32'h0000_0000);

  // A zero word is the normal end-of-program marker, so it is excluded here
  // and never reported as illegal.
`ifdef BUSCA_ILLEGAL_HALT_EN
  assign w_isIllegal = !w_isZero &&
                       ((w_word[1:0] != 2'b11) ||
                        !(w_word[6:0] inside {7'b0000011, 7'b0100011,
                                              7'b0110011, 7'b1100011}));
`else
  assign w_isIllegal = 1'b0;
`endif

  // Branch offset is added in word units; bits [1:0] of a B-type immediate
  // cannot move the PC off a word boundary.
  assign w_branchTarget = r_pcOutWord + r_imm[31:2];

  // State register: reset returns to IDLE, otherwise follow the decision
  // computed by the next-state logic below.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state and action decode. In RUN a taken branch outranks stall, and
  // the halt conditions are only evaluated on an ordinary fetch cycle. In
  // IDLE a program write blocks start for that cycle.
  always_comb begin
    w_stateNext = r_state;
    w_doFetch   = 1'b0;
    w_doBranch  = 1'b0;
    w_doHalt    = 1'b0;
    case (r_state)
      IDLE: begin
        if (!bus.prog_we && bus.start) begin
          w_stateNext = RUN;
        end
      end
      RUN: begin
        if (bus.branch_taken) begin
          w_doBranch = 1'b1;
        end else if (!bus.stall) begin
          if (w_outOfRange || w_isZero || w_isIllegal) begin
            w_doHalt    = 1'b1;
            w_stateNext = HALT;
          end else begin
            w_doFetch = 1'b1;
          end
        end
      end
      HALT: begin
        w_stateNext = HALT;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // Program memory: written only while IDLE and never cleared by reset, so
  // a program survives a mid-run reset.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && bus.prog_we) begin
      r_mem[bus.prog_addr] <= bus.prog_data;
    end
  end

  // Fetch datapath. A branch rewrites the PC and squashes the slot; a halt
  // only drops valid; a normal fetch loads every field and advances the PC.
  // Stall (or any other idle cycle) leaves every register untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pcWord    <= '0;
      r_pcOutWord <= '0;
      r_tipo      <= '0;
      r_funct3    <= '0;
      r_funct7    <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rd        <= '0;
      r_imm       <= '0;
      r_valid     <= 1'b0;
    end else if (w_doBranch) begin
      r_pcWord <= w_branchTarget;
      r_valid  <= 1'b0;
    end else if (w_doHalt) begin
      r_valid <= 1'b0;
    end else if (w_doFetch) begin
      r_tipo      <= w_word[6:4];
      r_funct3    <= w_word[14:12];
      r_funct7    <= w_word[31:25];
      r_rs1       <= w_word[19:15];
      r_rs2       <= w_word[24:20];
      r_rd        <= w_word[11:7];
      r_imm       <= selectImm(w_word);
      r_pcOutWord <= r_pcWord;
      r_pcWord    <= r_pcWord + 30'd1;
      r_valid     <= 1'b1;
    end
  end

`ifdef BUSCA_ILLEGAL_HALT_EN
  logic r_illegal;

  // Illegal flag latches on the halting edge when the cause was the opcode
  // check rather than running off the end of memory or hitting a zero word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_illegal <= 1'b0;
    end else if (w_doHalt && w_isIllegal && !w_outOfRange) begin
      r_illegal <= 1'b1;
    end
  end

  assign bus.illegal = r_illegal;
`else
  assign bus.illegal = 1'b0;
`endif

  assign bus.tipo   = r_tipo;
  assign bus.funct3 = r_funct3;
  assign bus.funct7 = r_funct7;
  assign bus.rs1    = r_rs1;
  assign bus.rs2    = r_rs2;
  assign bus.rd     = r_rd;
  assign bus.imm    = r_imm;
  assign bus.pc_out = {r_pcOutWord, 2'b00};
  assign bus.valid  = r_valid;
  assign bus.halted = (r_state == HALT);

endmodule

// File: tb/tb_busca_instrucao.sv
// ---------------------------------------------------------------------------
// tb_busca_instrucao
//   Scoreboard bench for busca_instrucao. Each test pushes the instructions
//   it expects to see issued; a monitor pops one entry on every cycle the
//   DUT presents valid=1 and compares all fields. Control-level behaviour
//   (squash, stall hold, halt, reset) is checked directly by the stimulus.
// ---------------------------------------------------------------------------
module tb_busca_instrucao;

  localparam int MEM_WORDS = 64;
  localparam int ADDR_W    = 6;

  localparam logic [31:0] INSTR_LW     = 32'h0040_2083; // lw x1,4(x0)
  localparam logic [31:0] INSTR_ADD    = 32'h0020_81B3; // add x3,x1,x2
  localparam logic [31:0] INSTR_BEQ    = 32'hFE00_0CE3; // beq x0,x0,-8
  localparam logic [31:0] INSTR_SW     = 32'h0053_2623; // sw x5,12(x6)
  localparam logic [31:0] INSTR_SWNEG  = 32'hFE20_AE23; // sw x2,-4(x1)
  localparam logic [31:0] INSTR_LWNEG  = 32'hFFF1_2383; // lw x7,-1(x2)
  localparam logic [31:0] INSTR_ADDI   = 32'h0000_0013; // addi x0,x0,0

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  busca_instrucao_if #(.ADDR_W(ADDR_W)) bus();

  busca_instrucao #(
    .MEM_WORDS(MEM_WORDS),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [2:0]  tipo;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] pc;
  } exp_t;

  exp_t expQ[$];
  exp_t expCur;
  int   checks = 0;
  int   errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, expected);
    end
  endtask

  task automatic pushExp(input logic [2:0] tipo, input logic [2:0] funct3,
                         input logic [6:0] funct7, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [31:0] imm, input logic [31:0] pc);
    exp_t e;
    e.tipo = tipo; e.funct3 = funct3; e.funct7 = funct7;
    e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.imm = imm; e.pc = pc;
    expQ.push_back(e);
  endtask

  // Hand-decoded expectations for the fixed instruction words above.
  task automatic pushLw(input logic [31:0] pc);
    pushExp(3'b000, 3'd2, 7'h00, 5'd0, 5'd4, 5'd1, 32'h0000_0004, pc);
  endtask
  task automatic pushAdd(input logic [31:0] pc);
    pushExp(3'b011, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'h0000_0000, pc);
  endtask
  task automatic pushBeq(input logic [31:0] pc);
    pushExp(3'b110, 3'd0, 7'h7F, 5'd0, 5'd0, 5'd25, 32'hFFFF_FFF8, pc);
  endtask

  // Monitor: every cycle with valid=1 must match the next queued entry.
  always @(negedge clk) begin
    if (bus.valid === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedIssue: got pc_out 0x%08h, required no issue", bus.pc_out);
      end else begin
        expCur = expQ.pop_front();
        checkOutput($sformatf("pc_out@%0h", expCur.pc), bus.pc_out, expCur.pc);
        checkOutput($sformatf("tipo@%0h", expCur.pc), {29'b0, bus.tipo}, {29'b0, expCur.tipo});
        checkOutput($sformatf("funct3@%0h", expCur.pc), {29'b0, bus.funct3}, {29'b0, expCur.funct3});
        checkOutput($sformatf("funct7@%0h", expCur.pc), {25'b0, bus.funct7}, {25'b0, expCur.funct7});
        checkOutput($sformatf("rs1@%0h", expCur.pc), {27'b0, bus.rs1}, {27'b0, expCur.rs1});
        checkOutput($sformatf("rs2@%0h", expCur.pc), {27'b0, bus.rs2}, {27'b0, expCur.rs2});
        checkOutput($sformatf("rd@%0h", expCur.pc), {27'b0, bus.rd}, {27'b0, expCur.rd});
        checkOutput($sformatf("imm@%0h", expCur.pc), bus.imm, expCur.imm);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs, let the edge sample them, then return to idle.
  task automatic applyStimulus(input logic we, input logic [ADDR_W-1:0] addr,
                               input logic [31:0] data, input logic st,
                               input logic stl, input logic br);
    bus.prog_we      = we;
    bus.prog_addr    = addr;
    bus.prog_data    = data;
    bus.start        = st;
    bus.stall        = stl;
    bus.branch_taken = br;
    tick();
    bus.prog_we      = 1'b0;
    bus.prog_addr    = '0;
    bus.prog_data    = '0;
    bus.start        = 1'b0;
    bus.stall        = 1'b0;
    bus.branch_taken = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic waitValidPc(input logic [31:0] pc, input string name);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (bus.valid === 1'b1 && bus.pc_out === pc) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    if (!found) checkOutput(name, {31'b0, found}, 32'd1);
  endtask

  task automatic waitHalt(input string name);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (bus.halted === 1'b1) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    checkOutput(name, {31'b0, found}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset            = 1'b0;
    bus.prog_we      = 1'b0;
    bus.prog_addr    = '0;
    bus.prog_data    = '0;
    bus.start        = 1'b0;
    bus.stall        = 1'b0;
    bus.branch_taken = 1'b0;

    // Reset state
    doReset();
    checkOutput("resetValid", {31'b0, bus.valid}, 32'd0);
    checkOutput("resetHalted", {31'b0, bus.halted}, 32'd0);
    checkOutput("resetIllegal", {31'b0, bus.illegal}, 32'd0);
    checkOutput("resetPcOut", bus.pc_out, 32'd0);
    checkOutput("resetImm", bus.imm, 32'd0);
    checkOutput("resetRd", {27'b0, bus.rd}, 32'd0);
    checkOutput("resetTipo", {29'b0, bus.tipo}, 32'd0);

    // Basic program: lw, add, 0. The last write also raises start, which
    // must be ignored because the write takes priority.
    $display("[TB] test: basic fetch and zero-word halt");
    applyStimulus(1'b1, 6'd0, INSTR_LW, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 6'd1, INSTR_ADD, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 6'd2, 32'h0, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("writeOverStartValid", {31'b0, bus.valid}, 32'd0);
    checkOutput("writeOverStartHalted", {31'b0, bus.halted}, 32'd0);
    pushLw(32'd0);
    pushAdd(32'd4);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("startNotYetValid", {31'b0, bus.valid}, 32'd0);
    tick();
    checkOutput("firstFetchValid", {31'b0, bus.valid}, 32'd1);
    waitHalt("basicHalt");
    checkOutput("basicHaltValid", {31'b0, bus.valid}, 32'd0);
    checkOutput("basicHaltPcOut", bus.pc_out, 32'd4);
    checkOutput("basicHaltIllegal", {31'b0, bus.illegal}, 32'd0);

    // Taken beq at pc 8 back to pc 0, asserted together with stall to show
    // the branch wins.
    $display("[TB] test: taken branch squash and redirect");
    doReset();
    applyStimulus(1'b1, 6'd0, INSTR_ADD, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 6'd1, INSTR_LW, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 6'd2, INSTR_BEQ, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 6'd3, 32'h0, 1'b0, 1'b0, 1'b0);
    pushAdd(32'd0);
    pushLw(32'd4);
    pushBeq(32'd8);
    pushAdd(32'd0);
    pushLw(32'd4);
    pushBeq(32'd8);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    waitValidPc(32'd8, "beqIssueTimeout");
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
    checkOutput("branchSquashValid", {31'b0, bus.valid}, 32'd0);
    checkOutput("branchSquashHalted", {31'b0, bus.halted}, 32'd0);
    tick();
    checkOutput("branchTargetValid", {31'b0, bus.valid}, 32'd1);
    checkOutput("branchTargetPc", bus.pc_out, 32'd0);
    waitHalt("branchHalt");
    checkOutput("branchHaltPcOut", bus.pc_out, 32'd8);

    // Three stall cycles while pc 4 is on the outputs.
    $display("[TB] test: stall hold");
    doReset();
    applyStimulus(1'b1, 6'd0, INSTR_SW, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 6'd1, INSTR_SWNEG, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 6'd2, INSTR_LWNEG, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 6'd3, INSTR_ADD, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 6'd4, 32'h0, 1'b0, 1'b0, 1'b0);
    pushExp(3'b010, 3'd2, 7'h00, 5'd6, 5'd5, 5'd12, 32'h0000_000C, 32'd0);
    for (int k = 0; k < 4; k++) begin
      pushExp(3'b010, 3'd2, 7'h7F, 5'd1, 5'd2, 5'd28, 32'hFFFF_FFFC, 32'd4);
    end
    pushExp(3'b000, 3'd2, 7'h7F, 5'd2, 5'd31, 5'd7, 32'hFFFF_FFFF, 32'd8);
    pushAdd(32'd12);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    waitValidPc(32'd4, "stallEntryTimeout");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
      checkOutput("stallPcOut", bus.pc_out, 32'd4);
      checkOutput("stallValid", {31'b0, bus.valid}, 32'd1);
      checkOutput("stallImm", bus.imm, 32'hFFFF_FFFC);
    end
    tick();
    checkOutput("stallResumePc", bus.pc_out, 32'd8);
    waitHalt("stallHalt");
    checkOutput("stallHaltPcOut", bus.pc_out, 32'd12);

    // Full memory with no zero word: halt when the PC runs off the end.
    $display("[TB] test: end-of-memory halt");
    doReset();
    for (int i = 0; i < MEM_WORDS; i++) begin
      applyStimulus(1'b1, ADDR_W'(i),
                    32'h0020_8033 | (32'(i % 32) << 7) | (32'((i / 8) % 8) << 12),
                    1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < MEM_WORDS; i++) begin
      pushExp(3'b011, 3'((i / 8) % 8), 7'h00, 5'd1, 5'd2, 5'(i % 32), 32'h0, 32'(4 * i));
    end
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    waitHalt("fullMemHalt");
    checkOutput("fullMemLastPc", bus.pc_out, 32'(4 * (MEM_WORDS - 1)));
    checkOutput("fullMemValid", {31'b0, bus.valid}, 32'd0);

    // Reset mid-run keeps memory; the restart refetches from pc 0.
    $display("[TB] test: reset during run");
    doReset();
    for (int i = 0; i < 3; i++) begin
      pushExp(3'b011, 3'((i / 8) % 8), 7'h00, 5'd1, 5'd2, 5'(i % 32), 32'h0, 32'(4 * i));
    end
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    waitValidPc(32'd8, "midRunTimeout");
    doReset();
    checkOutput("midResetValid", {31'b0, bus.valid}, 32'd0);
    checkOutput("midResetPcOut", bus.pc_out, 32'd0);
    checkOutput("midResetHalted", {31'b0, bus.halted}, 32'd0);
    for (int i = 0; i < MEM_WORDS; i++) begin
      pushExp(3'b011, 3'((i / 8) % 8), 7'h00, 5'd1, 5'd2, 5'(i % 32), 32'h0, 32'(4 * i));
    end
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    waitHalt("restartHalt");
    checkOutput("restartLastPc", bus.pc_out, 32'(4 * (MEM_WORDS - 1)));

    // addi at pc 4: illegal when opcode checking is built in, issued otherwise.
    $display("[TB] test: addi at pc 4");
    doReset();
    applyStimulus(1'b1, 6'd0, INSTR_LW, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 6'd1, INSTR_ADDI, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 6'd2, INSTR_ADD, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 6'd3, 32'h0, 1'b0, 1'b0, 1'b0);
    pushLw(32'd0);
`ifdef BUSCA_ILLEGAL_HALT_EN
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    waitHalt("illegalHalt");
    checkOutput("illegalFlag", {31'b0, bus.illegal}, 32'd1);
    checkOutput("illegalPcOut", bus.pc_out, 32'd0);
    checkOutput("illegalValid", {31'b0, bus.valid}, 32'd0);
`else
    pushExp(3'b001, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h0, 32'd4);
    pushAdd(32'd8);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    waitHalt("addiHalt");
    checkOutput("addiIllegalFlag", {31'b0, bus.illegal}, 32'd0);
    checkOutput("addiHaltPcOut", bus.pc_out, 32'd8);
`endif

    tick();
    tick();
    checkOutput("queueDrained", 32'(expQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
